// File: rtl/sram_ctrl_pkg.sv
// Shared widths, FSM encoding and SRAM pin constants for the SRAM access controller.
package sram_ctrl_pkg;

    localparam int unsigned SRAM_ADDR_W     = 15;
    localparam int unsigned SRAM_DATA_W     = 32;
    localparam int unsigned SRAM_RESP_DEPTH = 4;
    localparam int unsigned LEN_W           = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

endpackage

// File: rtl/sram_resp_fifo.sv
// Synchronous response FIFO with occupancy count; head reads as zero while empty.
module sram_resp_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    assign head  = (count_q != '0) ? mem[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/sram_access_ctrl.sv
// SRAM initiator: single-word writes and credit-throttled burst reads with a response FIFO.
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = SRAM_ADDR_W,
    parameter int unsigned DATA_W     = SRAM_DATA_W,
    parameter int unsigned RESP_DEPTH = SRAM_RESP_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic              mem_enable,
    output logic              mem_read_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic [DATA_W-1:0] mem_data_in
);

    localparam int unsigned CNT_W = $clog2(RESP_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_LIM = SUM_W'(RESP_DEPTH);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic              en_last_q, en_last_d;
    logic              cap_q, cap_last_q;
    logic              mem_enable_d, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_dout_d;

    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W:0]   fifo_head;
    logic              pop;
    logic              rd_on_pins;
    logic [SUM_W-1:0]  credit_sum;
    logic              credit_ok;

    assign rd_on_pins = mem_enable && (mem_read_write == MEM_READ);
    assign pop        = resp_valid && resp_ready;
    // Beats already committed to the FIFO: buffered, on the pins, or being captured.
    assign credit_sum = {1'b0, fifo_count} + SUM_W'(rd_on_pins) + SUM_W'(cap_q);
    assign credit_ok  = credit_sum < DEPTH_LIM;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        beat_d       = beat_q;
        en_last_d    = 1'b0;
        mem_enable_d = 1'b0;
        mem_rw_d     = MEM_READ;
        mem_addr_d   = mem_address;
        mem_dout_d   = mem_data_out;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    len_d        = req_len;
                    mem_enable_d = 1'b1;
                    mem_addr_d   = req_addr;
                    if (req_write) begin
                        mem_rw_d   = MEM_WRITE;
                        mem_dout_d = req_wdata;
                        state_d    = ST_WRITE;
                    end else begin
                        // FIFO is empty on entry, so the first beat is issued with the accept.
                        addr_d    = req_addr + ADDR_W'(1);
                        beat_d    = LEN_W'(1);
                        en_last_d = (req_len == '0);
                        state_d   = (req_len == '0) ? ST_DRAIN : ST_READ;
                    end
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_READ: begin
                if (credit_ok) begin
                    mem_enable_d = 1'b1;
                    mem_addr_d   = addr_q;
                    addr_d       = addr_q + ADDR_W'(1);
                    beat_d       = beat_q + LEN_W'(1);
                    en_last_d    = (beat_q == len_q);
                    if (beat_q == len_q) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!rd_on_pins && !cap_q &&
                    ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop))) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            len_q          <= '0;
            beat_q         <= '0;
            en_last_q      <= 1'b0;
            cap_q          <= 1'b0;
            cap_last_q     <= 1'b0;
            mem_enable     <= 1'b0;
            mem_read_write <= MEM_READ;
            mem_address    <= '0;
            mem_data_out   <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            len_q          <= len_d;
            beat_q         <= beat_d;
            en_last_q      <= en_last_d;
            cap_q          <= rd_on_pins;
            cap_last_q     <= en_last_q;
            mem_enable     <= mem_enable_d;
            mem_read_write <= mem_rw_d;
            mem_address    <= mem_addr_d;
            mem_data_out   <= mem_dout_d;
        end
    end

    sram_resp_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (cap_q),
        .push_data ({cap_last_q, mem_data_in}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign req_ready  = reset && (state_q == ST_IDLE);
    assign resp_valid = (fifo_count != '0);
    assign resp_data  = fifo_head[DATA_W-1:0];
    assign resp_last  = fifo_head[DATA_W];

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a behavioural one-cycle-latency SRAM.
module tb_sram_access_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [14:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [7:0]  req_len = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_last;
    logic        mem_enable;
    logic        mem_read_write;
    logic [14:0] mem_address;
    logic [31:0] mem_data_out;
    logic [31:0] sram_rd;

    logic [31:0] sram [0:32767];

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] data_q[$];
    bit          last_q[$];
    logic [14:0] addr_q[$];
    logic [63:0] en_mask;
    int          rv_first;
    int          ready_seen;
    int          max_out;
    int          timed_out;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_enable && !mem_read_write) sram[mem_address] <= mem_data_out;
        if (mem_enable && mem_read_write) sram_rd <= sram[mem_address];
        else sram_rd <= '0;
    end

    sram_access_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_len        (req_len),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_last      (resp_last),
        .mem_enable     (mem_enable),
        .mem_read_write (mem_read_write),
        .mem_address    (mem_address),
        .mem_data_out   (mem_data_out),
        .mem_data_in    (sram_rd)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [14:0] a, input logic [31:0] d);
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_len   = 8'hA5;
        check($sformatf("wr_ready@%0h", a), 64'(req_ready), 64'd1);
        @(negedge clock);
        req_valid = 1'b0;
        req_write = 1'b0;
        check($sformatf("wr_en@%0h", a), 64'(mem_enable), 64'd1);
        check($sformatf("wr_rw@%0h", a), 64'(mem_read_write), 64'd0);
        check($sformatf("wr_addr@%0h", a), 64'(mem_address), 64'(a));
        check($sformatf("wr_data@%0h", a), 64'(mem_data_out), 64'(d));
        @(negedge clock);
        check($sformatf("wr_idle@%0h", a), 64'(req_ready), 64'd1);
    endtask

    // Cycle 0 is the acceptance cycle; resp_ready is low for cycles st_lo..st_hi.
    task automatic do_read(input logic [14:0] a, input logic [7:0] len,
                           input int st_lo, input int st_hi, input bit hold);
        int issued;
        int popped;
        int n;
        data_q.delete();
        last_q.delete();
        addr_q.delete();
        en_mask    = '0;
        rv_first   = -1;
        ready_seen = 0;
        max_out    = 0;
        issued     = 0;
        popped     = 0;
        n          = int'(len) + 1;
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = a;
        req_len    = len;
        resp_ready = 1'b1;
        check($sformatf("rd_ready@%0h", a), 64'(req_ready), 64'd1);
        for (int cyc = 1; cyc < 300 && popped < n; cyc++) begin
            @(negedge clock);
            if (!hold) req_valid = 1'b0;
            resp_ready = !(cyc >= st_lo && cyc <= st_hi);
            if (mem_enable && mem_read_write) begin
                if (cyc < 64) en_mask[cyc] = 1'b1;
                addr_q.push_back(mem_address);
                issued++;
            end
            if (req_ready) ready_seen++;
            if (resp_valid && rv_first < 0) rv_first = cyc;
            if (resp_valid && resp_ready) begin
                data_q.push_back(resp_data);
                last_q.push_back(resp_last);
                popped++;
            end
            if (issued - popped > max_out) max_out = issued - popped;
        end
        req_valid = 1'b0;
        timed_out = (popped < n) ? 1 : 0;
        check($sformatf("rd_timeout@%0h", a), 64'(timed_out), 64'd0);
    endtask

    initial begin
        int seen;
        // Reset held with random inputs
        repeat (4) begin
            @(negedge clock);
            req_valid  = 1'($urandom);
            req_write  = 1'($urandom);
            req_addr   = 15'($urandom);
            req_wdata  = $urandom;
            req_len    = 8'($urandom);
            resp_ready = 1'($urandom);
        end
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_last", 64'(resp_last), 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        check("rst_mem_enable", 64'(mem_enable), 64'd0);
        check("rst_mem_rw", 64'(mem_read_write), 64'd1);
        check("rst_mem_addr", 64'(mem_address), 64'd0);
        check("rst_mem_dout", 64'(mem_data_out), 64'd0);
        @(negedge clock);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        reset      = 1'b1;
        #1;
        check("rel_req_ready", 64'(req_ready), 64'd1);

        // Write then single-beat read of the same word
        do_write(15'h0010, 32'hDEADBEEF);
        do_read(15'h0010, 8'd0, 100, 100, 1'b0);
        check("r0_latency", 64'(rv_first), 64'd3);
        check("r0_beats", 64'(data_q.size()), 64'd1);
        if (data_q.size() == 1) begin
            check("r0_data", 64'(data_q[0]), 64'hDEADBEEF);
            check("r0_last", 64'(last_q[0]), 64'd1);
        end
        check("r0_mask", en_mask, 64'h2);
        @(negedge clock);
        check("r0_idle", 64'(req_ready), 64'd1);

        // Wrapping burst
        do_write(15'h7FFE, 32'hAAAA0001);
        do_write(15'h7FFF, 32'hBBBB0002);
        do_write(15'h0000, 32'hCCCC0003);
        do_write(15'h0001, 32'hDDDD0004);
        do_read(15'h7FFE, 8'd3, 100, 100, 1'b0);
        check("wrap_mask", en_mask, 64'h1E);
        check("wrap_naddr", 64'(addr_q.size()), 64'd4);
        if (addr_q.size() == 4) begin
            check("wrap_a0", 64'(addr_q[0]), 64'h7FFE);
            check("wrap_a1", 64'(addr_q[1]), 64'h7FFF);
            check("wrap_a2", 64'(addr_q[2]), 64'h0000);
            check("wrap_a3", 64'(addr_q[3]), 64'h0001);
        end
        check("wrap_beats", 64'(data_q.size()), 64'd4);
        if (data_q.size() == 4) begin
            check("wrap_d0", 64'(data_q[0]), 64'hAAAA0001);
            check("wrap_d1", 64'(data_q[1]), 64'hBBBB0002);
            check("wrap_d2", 64'(data_q[2]), 64'hCCCC0003);
            check("wrap_d3", 64'(data_q[3]), 64'hDDDD0004);
            check("wrap_lasts", 64'({last_q[0], last_q[1], last_q[2], last_q[3]}), 64'b0001);
        end

        // 8-beat read with consumer stalled for cycles 4..10
        for (int i = 0; i < 8; i++) do_write(15'h0100 + 15'(i), 32'h1000_0000 + 32'(i));
        do_read(15'h0100, 8'd7, 4, 10, 1'b0);
        check("stall_mask", en_mask, 64'hE03E);
        check("stall_max_out", 64'(max_out), 64'd4);
        check("stall_beats", 64'(data_q.size()), 64'd8);
        for (int i = 0; i < data_q.size() && i < 8; i++) begin
            check($sformatf("stall_d%0d", i), 64'(data_q[i]), 64'h1000_0000 + 64'(i));
            check($sformatf("stall_l%0d", i), 64'(last_q[i]), (i == 7) ? 64'd1 : 64'd0);
        end

        // req_valid held high through a burst
        do_read(15'h7FFE, 8'd3, 100, 100, 1'b1);
        check("hold_ready_seen", 64'(ready_seen), 64'd0);
        check("hold_mask", en_mask, 64'h1E);
        check("hold_beats", 64'(data_q.size()), 64'd4);
        if (data_q.size() == 4) check("hold_d3", 64'(data_q[3]), 64'hDDDD0004);
        @(negedge clock);
        check("hold_idle", 64'(req_ready), 64'd1);
        check("hold_no_extra", 64'(mem_enable), 64'd0);

        // Reset in the middle of a 16-beat burst
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 15'h0200;
        req_len    = 8'd15;
        resp_ready = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (4) @(negedge clock);
        check("mid_active", 64'(mem_enable), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_en", 64'(mem_enable), 64'd0);
        check("mid_rst_rv", 64'(resp_valid), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        seen = 0;
        repeat (3) begin
            @(negedge clock);
            if (resp_valid || mem_enable) seen++;
        end
        check("mid_rst_quiet", 64'(seen), 64'd0);
        reset = 1'b1;
        #1;
        check("mid_rel_ready", 64'(req_ready), 64'd1);
        seen = 0;
        repeat (3) begin
            @(negedge clock);
            if (resp_valid) seen++;
        end
        check("mid_no_stale", 64'(seen), 64'd0);
        do_read(15'h7FFF, 8'd1, 100, 100, 1'b0);
        check("post_beats", 64'(data_q.size()), 64'd2);
        if (data_q.size() == 2) begin
            check("post_d0", 64'(data_q[0]), 64'hBBBB0002);
            check("post_d1", 64'(data_q[1]), 64'hCCCC0003);
            check("post_lasts", 64'({last_q[0], last_q[1]}), 64'b01);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
